hex_display_ctrl: RTL



---
 rtl/hex_display_pkg.sv | 35 +++
 rtl/hex_seg_decode.sv | 22 ++
 rtl/hex_display_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pkg
// Purpose  : Shared definitions for the hex display controller.
//            - Seven-segment codes for hex digits 0..F, bit order gfedcba,
//              active-low (a lit segment is 0).
//            - The blank code (every segment off).
//            - A polarity helper that converts an active-low code to the
//              output level selected by the ACTIVE_LOW parameter.
//            - A width helper for counters and indices.
// Revision : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

  // Entry k holds the code for hex digit k.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,   // F..8
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40    // 7..0
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low code in, pin level out.
  function automatic logic [6:0] apply_pol(input logic [6:0] code_al,
                                           input logic       active_low);
    return active_low ? code_al : ~code_al;
  endfunction

  // Bits needed to hold the values 0..n-1; never less than 1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : hex_seg_decode
// Purpose  : Combinational nibble to seven-segment decoder, active-low
//            output. A set blank_i forces every segment off.
// Ports    : nibble_i [3:0] - hex digit to show
//            blank_i        - force a blank digit
//            seg_o    [6:0] - active-low segment code, gfedcba
// Revision : 1.0 - initial release
// ============================================================================
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : SEG_CODES[nibble_i];

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Purpose  : Shows the most recently received UART bytes as a rolling hex
//            history on a seven-segment display. The display is driven two
//            ways at once: a parallel bus carrying every digit, and a
//            time-multiplexed scan (common segment bus plus one-hot digit
//            enable). Also provides leading-zero blanking, a receive-activity
//            decimal point on digit 0 and a synchronous clear.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            rx_data [7:0]         - received byte
//            rx_valid              - one-cycle strobe qualifying rx_data
//            clear                 - synchronous clear of history/activity
//            blank_lz              - enable leading-zero blanking
//            seg_par [7*N-1:0]     - parallel segments, digit i at [7i+6:7i]
//            seg_mux [6:0]         - scanned segment bus
//            dp_mux                - scanned decimal point
//            dig_en  [N-1:0]       - one-hot scanned digit enable
//            activity              - high while the activity hold runs
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 5000000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    clear,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] seg_par,
  output logic [6:0]              seg_mux,
  output logic                    dp_mux,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    activity
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int DIV_W = cnt_width(SCAN_DIV);
  localparam int ACT_W = cnt_width(HOLD_CYCLES + 1);
  localparam int IDX_W = cnt_width(NUM_DIGITS);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);
  localparam logic [ACT_W-1:0] c_hold     = ACT_W'(HOLD_CYCLES);

  logic [DW-1:0]    disp_q,    disp_d;
  logic [ACT_W-1:0] act_q,     act_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [6:0]       seg_mux_q, seg_mux_d;
  logic             dp_mux_q,  dp_mux_d;

  logic [3:0]            w_nib [NUM_DIGITS];
  logic [6:0]            w_seg_al [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_blank;
  logic [NUM_DIGITS-1:0] w_en_onehot;
  logic [6:0]            w_scan_seg_al;
  logic                  w_gap;
  logic                  w_active;

  assign w_active = (act_q != '0);
  assign w_gap    = (div_q == '0);

  // Leading-zero run from the top digit down. Digit 0 always shows.
  always_comb begin
    logic lz;
    lz      = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz         = lz && (w_nib[i] == 4'h0);
      w_blank[i] = blank_lz && (i != 0) && lz;
    end
  end

  // Parallel path: one decoder per digit.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nib[gi] = disp_q[4*gi +: 4];

      hex_seg_decode u_dec (
        .nibble_i (w_nib[gi]),
        .blank_i  (w_blank[gi]),
        .seg_o    (w_seg_al[gi])
      );

      assign seg_par[7*gi +: 7] = apply_pol(w_seg_al[gi], ACTIVE_LOW);
    end
  endgenerate

  // Scan path: one shared decoder addressed by the current slot.
  hex_seg_decode u_scan_dec (
    .nibble_i (w_nib[idx_q]),
    .blank_i  (w_blank[idx_q]),
    .seg_o    (w_scan_seg_al)
  );

  always_comb begin
    // History and activity; clear wins over a same-cycle byte.
    disp_d = disp_q;
    act_d  = act_q;
    if (clear) begin
      disp_d = '0;
      act_d  = '0;
    end else if (rx_valid) begin
      // The cast keeps the low DW bits, dropping the oldest byte.
      disp_d = DW'({disp_q, rx_data});
      act_d  = c_hold;
    end else if (w_active) begin
      act_d = act_q - 1'b1;
    end

    // Scan slot timing.
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == c_div_last) begin
      div_d = '0;
      idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
    end

    // Scan outputs settle during the gap cycle, while every digit is off.
    seg_mux_d = seg_mux_q;
    dp_mux_d  = dp_mux_q;
    if (w_gap) begin
      seg_mux_d = apply_pol(w_scan_seg_al, ACTIVE_LOW);
      dp_mux_d  = ((idx_q == '0) && w_active) ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q    <= '0;
      act_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      seg_mux_q <= apply_pol(SEG_BLANK, ACTIVE_LOW);
      dp_mux_q  <= ACTIVE_LOW;
    end else begin
      disp_q    <= disp_d;
      act_q     <= act_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      seg_mux_q <= seg_mux_d;
      dp_mux_q  <= dp_mux_d;
    end
  end

  always_comb begin
    w_en_onehot = '0;
    if (!w_gap) w_en_onehot[idx_q] = 1'b1;
  end

  assign dig_en   = ACTIVE_LOW ? ~w_en_onehot : w_en_onehot;
  assign seg_mux  = seg_mux_q;
  assign dp_mux   = dp_mux_q;
  assign activity = w_active;

endmodule
`default_nettype wire
